// File: rtl/stack_hazard_ctl_pkg.sv
// Shared definitions for the decode-stage operand-stack scheduler.
// Holds the field widths, the architectural stack limit, the in-flight
// stage-entry record and the commit latency (issue to commit strobe).
package stack_hazard_ctl_pkg;

  localparam int unsigned DEPTH_W       = 11;
  localparam int unsigned PUSH_W        = 3;
  localparam int unsigned STACK_SIZE    = 1024;
  localparam int unsigned CommitLatency = 4;

  typedef struct packed {
    logic              v;
    logic [PUSH_W-1:0] push;
    logic [DEPTH_W-1:0] pop;
  } stage_entry_t;

  // An entry only blocks decode if it will actually change the stack.
  function automatic logic entry_busy(stage_entry_t e);
    return e.v && ((e.push != '0) || (e.pop != '0));
  endfunction

endpackage

// File: rtl/stack_hazard_stage.sv
// One in-flight pipeline slot of the stack scheduler.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   hold_i    - freeze the slot (downstream stall)
//   kill_i    - clear the valid bit of the entry being captured
//   d_i       - entry from the previous stage
//   q_o       - registered entry
module stack_hazard_stage
  import stack_hazard_ctl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hold_i,
  input  logic         kill_i,
  input  stage_entry_t d_i,
  output stage_entry_t q_o
);

  stage_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (!hold_i) begin
      entry_d   = d_i;
      entry_d.v = d_i.v & ~kill_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign q_o = entry_q;

endmodule

// File: rtl/stack_hazard_ctl.sv
// Decode-stage operand-stack scheduler.
// Tracks the stack effect of instructions in 3a/4a/5a, stalls decode while
// older stack writes are pending, issues registered 5a commit controls and
// keeps the architectural depth with sticky underflow/overflow error.
// Optional: define STACK_DEPTH_CHECK_EN to enable overflow clamping against
// STACK_SIZE and the overflow-avoidance stall; otherwise depth wraps.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   issue_2a              - decode holds a valid instruction
//   c__to_push_2a         - pushes of the 2a instruction
//   st__to_pop_2a         - pops of the 2a instruction
//   pipe_hold             - freezes stages 3a-5a
//   kill_4a               - squash the entry moving into 4a and the 2a load
//   stall_2a              - decode must hold
//   st__push_5a           - commit push strobe
//   st__to_pop_5a         - committed pop count
//   c__to_push_5a         - committed push count
//   st__depth             - architectural stack depth
//   st__err               - sticky underflow/overflow flag
module stack_hazard_ctl
  import stack_hazard_ctl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_2a,
  input  logic [PUSH_W-1:0]  c__to_push_2a,
  input  logic [DEPTH_W-1:0] st__to_pop_2a,
  input  logic               pipe_hold,
  input  logic               kill_4a,
  output logic               stall_2a,
  output logic               st__push_5a,
  output logic [DEPTH_W-1:0] st__to_pop_5a,
  output logic [PUSH_W-1:0]  c__to_push_5a,
  output logic [DEPTH_W-1:0] st__depth,
  output logic               st__err
);

  stage_entry_t s3_in, s3_q, s4_q, s5_q;
  logic         hazard;
  logic         ovf_stall;

  logic               push_5a_d, push_5a_q;
  logic [DEPTH_W-1:0] pop_5a_d, pop_5a_q;
  logic [PUSH_W-1:0]  cpush_5a_d, cpush_5a_q;
  logic [DEPTH_W-1:0] depth_d, depth_q;
  logic               err_d, err_q;
  logic [DEPTH_W:0]   depth_sum;

  assign hazard = entry_busy(s3_q) || entry_busy(s4_q) || entry_busy(s5_q);

`ifdef STACK_DEPTH_CHECK_EN
  // Worst-case depth once everything in flight (and the 2a candidate) lands;
  // pops are ignored so the check stays conservative.
  logic [DEPTH_W+2:0] pend_sum;
  always_comb begin
    pend_sum = (DEPTH_W+3)'(depth_q)
             + (DEPTH_W+3)'(s3_q.v ? s3_q.push : '0)
             + (DEPTH_W+3)'(s4_q.v ? s4_q.push : '0)
             + (DEPTH_W+3)'(s5_q.v ? s5_q.push : '0)
             + (DEPTH_W+3)'(cpush_5a_q)
             + (DEPTH_W+3)'(c__to_push_2a);
  end
  assign ovf_stall = pend_sum > (DEPTH_W+3)'(STACK_SIZE);
`else
  assign ovf_stall = 1'b0;
`endif

  assign stall_2a = pipe_hold || (issue_2a && hazard) || ovf_stall;

  always_comb begin
    s3_in      = '0;
    s3_in.v    = issue_2a && !stall_2a && !kill_4a;
    s3_in.push = c__to_push_2a;
    s3_in.pop  = st__to_pop_2a;
  end

  stack_hazard_stage u_stage_3a (
    .clk    (clk),
    .rst    (rst),
    .hold_i (pipe_hold),
    .kill_i (1'b0),
    .d_i    (s3_in),
    .q_o    (s3_q)
  );

  // Kill squashes the old 3a entry as it moves into 4a.
  stack_hazard_stage u_stage_4a (
    .clk    (clk),
    .rst    (rst),
    .hold_i (pipe_hold),
    .kill_i (kill_4a),
    .d_i    (s3_q),
    .q_o    (s4_q)
  );

  stack_hazard_stage u_stage_5a (
    .clk    (clk),
    .rst    (rst),
    .hold_i (pipe_hold),
    .kill_i (1'b0),
    .d_i    (s4_q),
    .q_o    (s5_q)
  );

  // Commit controls are registered; zero whenever nothing commits.
  always_comb begin
    push_5a_d  = 1'b0;
    pop_5a_d   = '0;
    cpush_5a_d = '0;
    if (!pipe_hold && s5_q.v) begin
      push_5a_d  = s5_q.push != '0;
      pop_5a_d   = s5_q.pop;
      cpush_5a_d = s5_q.push;
    end
  end

  // Depth follows the registered commit by one cycle.
  assign depth_sum = {1'b0, depth_q} - {1'b0, pop_5a_q}
                   + {{(DEPTH_W+1-PUSH_W){1'b0}}, cpush_5a_q};

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (pop_5a_q > depth_q) begin
      depth_d = '0;
      err_d   = 1'b1;
    end else begin
`ifdef STACK_DEPTH_CHECK_EN
      if (depth_sum > (DEPTH_W+1)'(STACK_SIZE)) begin
        depth_d = DEPTH_W'(STACK_SIZE);
        err_d   = 1'b1;
      end else begin
        depth_d = depth_sum[DEPTH_W-1:0];
      end
`else
      depth_d = depth_sum[DEPTH_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_5a_q  <= 1'b0;
      pop_5a_q   <= '0;
      cpush_5a_q <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      push_5a_q  <= push_5a_d;
      pop_5a_q   <= pop_5a_d;
      cpush_5a_q <= cpush_5a_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
    end
  end

  assign st__push_5a   = push_5a_q;
  assign st__to_pop_5a = pop_5a_q;
  assign c__to_push_5a = cpush_5a_q;
  assign st__depth     = depth_q;
  assign st__err       = err_q;

endmodule

// File: tb/tb_stack_hazard_ctl.sv
module tb_stack_hazard_ctl;
  import stack_hazard_ctl_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               issue_2a;
  logic [PUSH_W-1:0]  c__to_push_2a;
  logic [DEPTH_W-1:0] st__to_pop_2a;
  logic               pipe_hold;
  logic               kill_4a;
  logic               stall_2a;
  logic               st__push_5a;
  logic [DEPTH_W-1:0] st__to_pop_5a;
  logic [PUSH_W-1:0]  c__to_push_5a;
  logic [DEPTH_W-1:0] st__depth;
  logic               st__err;

  stack_hazard_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .issue_2a      (issue_2a),
    .c__to_push_2a (c__to_push_2a),
    .st__to_pop_2a (st__to_pop_2a),
    .pipe_hold     (pipe_hold),
    .kill_4a       (kill_4a),
    .stall_2a      (stall_2a),
    .st__push_5a   (st__push_5a),
    .st__to_pop_5a (st__to_pop_5a),
    .c__to_push_5a (c__to_push_5a),
    .st__depth     (st__depth),
    .st__err       (st__err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: in-flight instructions in program order, each with its
  // distance from decode (0 = 3a, 1 = 4a, 2 = 5a).
  typedef struct {int push; int pop; int pos;} rec_t;
  rec_t q[$];
  int   m_depth;
  bit   m_err;
  bit   pend_v;
  int   pend_push, pend_pop;
  bit   st_e;
  bit   obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_busy();
    foreach (q[i]) if (q[i].push != 0 || q[i].pop != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    m_depth = 0; m_err = 0;
    pend_v = 0; pend_push = 0; pend_pop = 0;
    st_e = 0;
  endtask

  task automatic check_outputs();
    chk("stall_2a", stall_2a, st_e);
    chk("st__push_5a", st__push_5a, (pend_v && pend_push != 0));
    chk("st__to_pop_5a", st__to_pop_5a, pend_pop);
    chk("c__to_push_5a", c__to_push_5a, pend_push);
    chk("st__depth", st__depth, m_depth);
    chk("st__err", st__err, m_err);
  endtask

  task automatic model_edge(input bit iss, input int pu, input int po, input bit hd,
                            input bit kl);
    if (pend_v) begin
      if (pend_pop > m_depth) begin
        m_depth = 0;
        m_err   = 1;
      end else begin
        m_depth = (m_depth - pend_pop + pend_push) % 2048;
      end
    end
    pend_v = 0; pend_push = 0; pend_pop = 0;
    if (!hd) begin
      if (q.size() > 0 && q[0].pos == 2) begin
        pend_v = 1; pend_push = q[0].push; pend_pop = q[0].pop;
        void'(q.pop_front());
      end
      if (kl && q.size() > 0 && q[q.size()-1].pos == 0) void'(q.pop_back());
      foreach (q[i]) q[i].pos++;
      if (iss && !st_e && !kl) q.push_back('{push: pu, pop: po, pos: 0});
    end
  endtask

  // Called just after a rising edge; drives inputs, checks at the falling edge.
  task automatic step(input bit iss, input int pu, input int po, input bit hd, input bit kl);
    issue_2a      = iss;
    c__to_push_2a = PUSH_W'(pu);
    st__to_pop_2a = DEPTH_W'(po);
    pipe_hold     = hd;
    kill_4a       = kl;
    st_e = hd || (iss && model_busy());
    @(negedge clk);
    obs_stall = stall_2a;
    check_outputs();
    @(posedge clk);
    model_edge(iss, pu, po, hd, kl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_2a = 0; c__to_push_2a = '0; st__to_pop_2a = '0; pipe_hold = 0; kill_4a = 0;
    model_clear();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls;
    int n;

    // Plain push commits CommitLatency cycles after issue; depth one later.
    do_reset();
    step(1, 1, 0, 0, 0);
    idle(CommitLatency + 1);
    chk("seq1_depth", st__depth, 1);

    // Dependent pop stalls until the push leaves 5a.
    do_reset();
    step(1, 1, 0, 0, 0);
    stalls = 0;
    n = 0;
    do begin
      step(1, 0, 1, 0, 0);
      if (obs_stall) stalls++;
      n++;
    end while (obs_stall && n < 10);
    chk("seq2_stall_cycles", stalls, 3);
    idle(6);
    chk("seq2_depth", st__depth, 0);
    chk("seq2_err", st__err, 0);

    // Kill while A sits in 4a and again in 5a: A still commits.
    // Then kill B while it sits in 3a: B never commits.
    do_reset();
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(3);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(6);
    chk("seq3_depth", st__depth, 2);

    // Hold for 5 cycles with the entry in 5a.
    do_reset();
    step(1, 3, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    idle(4);
    chk("seq4_depth", st__depth, 3);

    // Underflow from empty, error stays through a good commit.
    do_reset();
    step(1, 0, 2, 0, 0);
    idle(6);
    chk("seq5_err", st__err, 1);
    chk("seq5_depth", st__depth, 0);
    step(1, 3, 0, 0, 0);
    idle(6);
    chk("seq5_err_sticky", st__err, 1);
    chk("seq5_depth_after", st__depth, 3);

    // Randomized traffic against the model, with a mid-flight reset.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        if (blk == 1 && i == 150) begin
          do_reset();
        end
        step($urandom_range(0, 99) < 60,
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)),
             $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 10);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
